// File: rtl/eva_pkg.sv
// rtl/eva_pkg.sv - shared widths, FSM state type and score saturation for the EVA rank updater
package eva_pkg;

  localparam int AGE_W_DEF      = 7;
  localparam int HIST_W_DEF     = 16;
  localparam int SCORE_W_DEF    = 16;
  localparam int GAIN_SHIFT_DEF = 4;

  // hits/events accumulators: one histogram width plus room for 2*NUM_AGES additions
  function automatic int cnt_width(input int hist_w, input int age_w);
    return hist_w + age_w + 1;
  endfunction

  // life is a sum of up to NUM_AGES events accumulators
  function automatic int acc_width(input int hist_w, input int age_w);
    return hist_w + 1 + 2 * age_w;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_ACC  = 2'd2,
    S_DONE = 2'd3
  } eva_state_e;

  function automatic logic signed [63:0] sat_score(input logic signed [63:0] v,
                                                   input int score_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (score_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (score_w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/eva_score_calc.sv
// rtl/eva_score_calc.sv - one age step of the EVA walk: accumulate hits/events/life and form the saturated score
module eva_score_calc
  import eva_pkg::*;
#(
  parameter  int HIST_W     = HIST_W_DEF,
  parameter  int AGE_W      = AGE_W_DEF,
  parameter  int SCORE_W    = SCORE_W_DEF,
  parameter  int GAIN_SHIFT = GAIN_SHIFT_DEF,
  localparam int CNT_W      = cnt_width(HIST_W, AGE_W),
  localparam int ACC_W      = acc_width(HIST_W, AGE_W)
) (
  input  logic [HIST_W-1:0]         h,
  input  logic [HIST_W-1:0]         e,
  input  logic [CNT_W-1:0]          hits_q,
  input  logic [CNT_W-1:0]          events_q,
  input  logic [ACC_W-1:0]          life_q,
  output logic [CNT_W-1:0]          hits_d,
  output logic [CNT_W-1:0]          events_d,
  output logic [ACC_W-1:0]          life_d,
  output logic signed [SCORE_W-1:0] score
);

  logic [ACC_W-1:0]      shifted_life;
  logic signed [ACC_W:0] diff;

  always_comb begin
    hits_d       = hits_q + CNT_W'(h);
    events_d     = events_q + CNT_W'(h) + CNT_W'(e);
    life_d       = life_q + ACC_W'(events_d);
    shifted_life = life_d >> GAIN_SHIFT;
    // both operands are non-negative, so a zero sign bit makes the subtraction exact
    diff         = $signed({1'b0, ACC_W'(hits_d)}) - $signed({1'b0, shifted_life});
    score        = SCORE_W'(sat_score(64'(diff), SCORE_W));
  end

endmodule

// File: rtl/eva_rank_update.sv
// rtl/eva_rank_update.sv - walks hit/evict histograms oldest to youngest, writes EVA ranks and optional decay
module eva_rank_update
  import eva_pkg::*;
#(
  parameter  int HIST_W     = HIST_W_DEF,
  parameter  int AGE_W      = AGE_W_DEF,
  parameter  int SCORE_W    = SCORE_W_DEF,
  parameter  int GAIN_SHIFT = GAIN_SHIFT_DEF,
  parameter  bit DECAY_EN   = 1'b1,
  localparam int CNT_W      = cnt_width(HIST_W, AGE_W),
  localparam int ACC_W      = acc_width(HIST_W, AGE_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                update_EVA,
  output logic                hist_rd_en,
  output logic [AGE_W-1:0]    hist_rd_addr,
  input  logic [HIST_W-1:0]   hit_cnt,
  input  logic [HIST_W-1:0]   evict_cnt,
  output logic                hist_wr_en,
  output logic [AGE_W-1:0]    hist_wr_addr,
  output logic [HIST_W-1:0]   hit_wr,
  output logic [HIST_W-1:0]   evict_wr,
  output logic                eva_wr_en,
  output logic [AGE_W-1:0]    eva_wr_addr,
  output logic [SCORE_W-1:0]  eva_wr_data,
  output logic                busy,
  output logic                done,
  output logic                eva_valid
);

  eva_state_e         state_q, state_d;
  logic [AGE_W-1:0]   age_q, age_d;
  logic               pending_q, pending_d;
  logic               eva_valid_q, eva_valid_d;
  logic [CNT_W-1:0]   hits_q, hits_d;
  logic [CNT_W-1:0]   events_q, events_d;
  logic [ACC_W-1:0]   life_q, life_d;

  logic [CNT_W-1:0]          calc_hits;
  logic [CNT_W-1:0]          calc_events;
  logic [ACC_W-1:0]          calc_life;
  logic signed [SCORE_W-1:0] calc_score;

  eva_score_calc #(
    .HIST_W     (HIST_W),
    .AGE_W      (AGE_W),
    .SCORE_W    (SCORE_W),
    .GAIN_SHIFT (GAIN_SHIFT)
  ) u_calc (
    .h        (hit_cnt),
    .e        (evict_cnt),
    .hits_q   (hits_q),
    .events_q (events_q),
    .life_q   (life_q),
    .hits_d   (calc_hits),
    .events_d (calc_events),
    .life_d   (calc_life),
    .score    (calc_score)
  );

  always_comb begin
    state_d      = state_q;
    age_d        = age_q;
    pending_d    = pending_q;
    eva_valid_d  = eva_valid_q;
    hits_d       = hits_q;
    events_d     = events_q;
    life_d       = life_q;
    hist_rd_en   = 1'b0;
    hist_rd_addr = '0;
    hist_wr_en   = 1'b0;
    hist_wr_addr = '0;
    hit_wr       = '0;
    evict_wr     = '0;
    eva_wr_en    = 1'b0;
    eva_wr_addr  = '0;
    eva_wr_data  = '0;
    busy         = 1'b1;
    done         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (update_EVA) begin
          state_d     = S_RD;
          age_d       = {AGE_W{1'b1}};
          hits_d      = '0;
          events_d    = '0;
          life_d      = '0;
          eva_valid_d = 1'b0;
        end
      end
      S_RD: begin
        hist_rd_en   = 1'b1;
        hist_rd_addr = age_q;
        if (update_EVA) pending_d = 1'b1;
        state_d = S_ACC;
      end
      S_ACC: begin
        hits_d      = calc_hits;
        events_d    = calc_events;
        life_d      = calc_life;
        eva_wr_en   = 1'b1;
        eva_wr_addr = age_q;
        eva_wr_data = calc_score;
        if (DECAY_EN) begin
          hist_wr_en   = 1'b1;
          hist_wr_addr = age_q;
          hit_wr       = hit_cnt >> 1;
          evict_wr     = evict_cnt >> 1;
        end
        if (update_EVA) pending_d = 1'b1;
        if (age_q == '0) begin
          state_d = S_DONE;
        end else begin
          age_d   = age_q - AGE_W'(1);
          state_d = S_RD;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        eva_valid_d = 1'b1;
        // a request arriving in DONE is absorbed into the back-to-back restart
        if (pending_q || update_EVA) begin
          pending_d = 1'b0;
          state_d   = S_RD;
          age_d     = {AGE_W{1'b1}};
          hits_d    = '0;
          events_d  = '0;
          life_d    = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign eva_valid = eva_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      age_q       <= '0;
      pending_q   <= 1'b0;
      eva_valid_q <= 1'b0;
      hits_q      <= '0;
      events_q    <= '0;
      life_q      <= '0;
    end else begin
      state_q     <= state_d;
      age_q       <= age_d;
      pending_q   <= pending_d;
      eva_valid_q <= eva_valid_d;
      hits_q      <= hits_d;
      events_q    <= events_d;
      life_q      <= life_d;
    end
  end

endmodule

// File: tb/tb_eva_rank_update.sv
// tb/tb_eva_rank_update.sv - randomized self-checking bench for eva_rank_update against an arithmetic EVA model
module tb_eva_rank_update;

  localparam int NA = 128;

  logic        clk;
  logic        rst;
  logic        update_EVA;
  logic        hist_rd_en;
  logic [6:0]  hist_rd_addr;
  logic [15:0] hit_cnt;
  logic [15:0] evict_cnt;
  logic        hist_wr_en;
  logic [6:0]  hist_wr_addr;
  logic [15:0] hit_wr;
  logic [15:0] evict_wr;
  logic        eva_wr_en;
  logic [6:0]  eva_wr_addr;
  logic [15:0] eva_wr_data;
  logic        busy;
  logic        done;
  logic        eva_valid;

  logic        g0_update;
  logic        g0_rd_en;
  logic [6:0]  g0_rd_addr;
  logic [15:0] g0_hit;
  logic [15:0] g0_evict;
  logic        g0_hwr_en;
  logic [6:0]  g0_hwr_addr;
  logic [15:0] g0_hit_wr;
  logic [15:0] g0_evict_wr;
  logic        g0_eva_en;
  logic [6:0]  g0_eva_addr;
  logic [15:0] g0_eva_data;
  logic        g0_busy;
  logic        g0_done;
  logic        g0_valid;

  eva_rank_update dut (
    .clk(clk), .rst(rst), .update_EVA(update_EVA),
    .hist_rd_en(hist_rd_en), .hist_rd_addr(hist_rd_addr),
    .hit_cnt(hit_cnt), .evict_cnt(evict_cnt),
    .hist_wr_en(hist_wr_en), .hist_wr_addr(hist_wr_addr),
    .hit_wr(hit_wr), .evict_wr(evict_wr),
    .eva_wr_en(eva_wr_en), .eva_wr_addr(eva_wr_addr), .eva_wr_data(eva_wr_data),
    .busy(busy), .done(done), .eva_valid(eva_valid)
  );

  eva_rank_update #(.GAIN_SHIFT(0)) dut_g0 (
    .clk(clk), .rst(rst), .update_EVA(g0_update),
    .hist_rd_en(g0_rd_en), .hist_rd_addr(g0_rd_addr),
    .hit_cnt(g0_hit), .evict_cnt(g0_evict),
    .hist_wr_en(g0_hwr_en), .hist_wr_addr(g0_hwr_addr),
    .hit_wr(g0_hit_wr), .evict_wr(g0_evict_wr),
    .eva_wr_en(g0_eva_en), .eva_wr_addr(g0_eva_addr), .eva_wr_data(g0_eva_data),
    .busy(g0_busy), .done(g0_done), .eva_valid(g0_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign g0_hit   = 16'hFFFF;
  assign g0_evict = 16'h0000;

  int mem_hit[NA];
  int mem_ev[NA];
  int ref_hit[NA];
  int ref_ev[NA];

  // histogram RAM: read data one cycle after the strobe, decay writes land in place
  always @(posedge clk) begin
    if (hist_rd_en) begin
      hit_cnt   <= 16'(mem_hit[hist_rd_addr]);
      evict_cnt <= 16'(mem_ev[hist_rd_addr]);
    end
    if (hist_wr_en) begin
      mem_hit[hist_wr_addr] = int'(hit_wr);
      mem_ev[hist_wr_addr]  = int'(evict_wr);
    end
  end

  int n_vec = 0;
  int n_err = 0;

  int exp_a[$], exp_d[$], exp_da[$], exp_dh[$], exp_de[$];
  int cap_a[$], cap_d[$], cap_da[$], cap_dh[$], cap_de[$];
  int done_at[$];
  bit rd_after_done[$];
  bit valid_at1;
  int idle_at;

  task automatic clear_exp();
    exp_a.delete(); exp_d.delete(); exp_da.delete(); exp_dh.delete(); exp_de.delete();
  endtask

  task automatic load_hist(input int mode);
    int h, e;
    for (int a = 0; a < NA; a++) begin
      case (mode)
        0:       begin h = 0; e = 0; end
        1:       begin h = $urandom_range(0, 255); e = $urandom_range(0, 255); end
        2:       begin h = $urandom_range(0, 65535); e = $urandom_range(0, 65535); end
        default: begin
          h = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4000) : 0;
          e = $urandom_range(0, 50);
        end
      endcase
      mem_hit[a] = h; mem_ev[a] = e;
      ref_hit[a] = h; ref_ev[a] = e;
    end
  endtask

  // EVA reference: running sums from the oldest age down, then clamp to 16-bit signed
  task automatic model_run(input int gs, input bit decay);
    longint hits, ev, life, s;
    hits = 0; ev = 0; life = 0;
    for (int a = NA - 1; a >= 0; a--) begin
      hits += ref_hit[a];
      ev   += ref_hit[a] + ref_ev[a];
      life += ev;
      s = hits - (life >> gs);
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      exp_a.push_back(a);
      exp_d.push_back(int'(s));
      if (decay) begin
        exp_da.push_back(a);
        exp_dh.push_back(ref_hit[a] / 2);
        exp_de.push_back(ref_ev[a] / 2);
        ref_hit[a] = ref_hit[a] / 2;
        ref_ev[a]  = ref_ev[a] / 2;
      end
    end
  endtask

  // pulse sampled at edge 0; further pulses sampled at edges p1/p2; n counts negedges after edge 0
  task automatic run_capture(input int p1, input int p2, input int max_cyc);
    bit prev_done;
    prev_done = 1'b0;
    cap_a.delete(); cap_d.delete(); cap_da.delete(); cap_dh.delete(); cap_de.delete();
    done_at.delete(); rd_after_done.delete();
    idle_at = -1;
    @(negedge clk);
    update_EVA = 1'b1;
    for (int n = 1; n <= max_cyc; n++) begin
      @(negedge clk);
      update_EVA = (n == p1 || n == p2);
      if (n == 1) valid_at1 = eva_valid;
      if (prev_done) rd_after_done.push_back(hist_rd_en);
      prev_done = done;
      if (done) done_at.push_back(n);
      if (eva_wr_en) begin
        cap_a.push_back(int'(eva_wr_addr));
        cap_d.push_back(int'($signed(eva_wr_data)));
      end
      if (hist_wr_en) begin
        cap_da.push_back(int'(hist_wr_addr));
        cap_dh.push_back(int'(hit_wr));
        cap_de.push_back(int'(evict_wr));
      end
      if (n > 2 && n > p1 + 2 && n > p2 + 2 && !busy) begin
        idle_at = n;
        break;
      end
    end
    update_EVA = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; update_EVA = 1'b1; g0_update = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if ({busy, done, eva_valid, hist_rd_en, hist_wr_en, eva_wr_en, g0_busy, g0_eva_en} !== 8'b0 ||
          eva_wr_addr !== 7'd0 || eva_wr_data !== 16'd0 || hist_rd_addr !== 7'd0) begin
        n_err++;
        $display("FAIL reset cyc%0d: busy=%b done=%b valid=%b rd=%b hwr=%b ewr=%b addr=%0d data=%0d, want all 0",
                 c, busy, done, eva_valid, hist_rd_en, hist_wr_en, eva_wr_en, eva_wr_addr, eva_wr_data);
      end
    end
    rst = 1'b0; update_EVA = 1'b0; g0_update = 1'b0;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || eva_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: busy=%b valid=%b, want 0 0", busy, eva_valid);
    end
  endtask

  task automatic test_zero_hist();
    load_hist(0);
    clear_exp();
    model_run(4, 1'b1);
    run_capture(-10, -10, 400);
    n_vec++;
    if (done_at.size() != 1 || done_at[0] != 257) begin
      n_err++;
      $display("FAIL zero_done_latency: got %0d pulses first=%0d, want 1 at 257",
               done_at.size(), (done_at.size() > 0) ? done_at[0] : -1);
    end
    n_vec++;
    if (valid_at1 !== 1'b0 || eva_valid !== 1'b1) begin
      n_err++;
      $display("FAIL zero_eva_valid: during=%b after=%b, want 0 1", valid_at1, eva_valid);
    end
    n_vec++;
    if (cap_a.size() != exp_a.size()) begin
      n_err++;
      $display("FAIL zero_write_count: got %0d, want %0d", cap_a.size(), exp_a.size());
    end
    for (int i = 0; i < exp_a.size() && i < cap_a.size(); i++) begin
      n_vec++;
      if (cap_a[i] != exp_a[i] || cap_d[i] != exp_d[i]) begin
        n_err++;
        $display("FAIL zero_eva[%0d]: got addr=%0d data=%0d, want addr=%0d data=%0d",
                 i, cap_a[i], cap_d[i], exp_a[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_single_hit();
    load_hist(0);
    mem_hit[5] = 100; ref_hit[5] = 100;
    clear_exp();
    model_run(4, 1'b1);
    run_capture(-10, -10, 400);
    n_vec++;
    if (cap_a.size() != NA || cap_da.size() != NA) begin
      n_err++;
      $display("FAIL hit5_counts: eva=%0d decay=%0d, want %0d", cap_a.size(), cap_da.size(), NA);
    end else begin
      for (int i = 0; i <= 121; i++) begin
        n_vec++;
        if (cap_d[i] != 0) begin
          n_err++;
          $display("FAIL hit5_old_age%0d: got %0d, want 0", cap_a[i], cap_d[i]);
        end
      end
      n_vec++;
      if (cap_d[122] != 94 || cap_d[123] != 88 || cap_d[127] != 63) begin
        n_err++;
        $display("FAIL hit5_scores: age5=%0d age4=%0d age0=%0d, want 94 88 63",
                 cap_d[122], cap_d[123], cap_d[127]);
      end
      n_vec++;
      if (cap_da[122] != 5 || cap_dh[122] != 50 || cap_de[122] != 0) begin
        n_err++;
        $display("FAIL hit5_decay: addr=%0d hit_wr=%0d evict_wr=%0d, want 5 50 0",
                 cap_da[122], cap_dh[122], cap_de[122]);
      end
      for (int i = 0; i < NA; i++) begin
        n_vec++;
        if (cap_d[i] != exp_d[i] || cap_dh[i] != exp_dh[i]) begin
          n_err++;
          $display("FAIL hit5_model[%0d]: got data=%0d hit_wr=%0d, want %0d %0d",
                   i, cap_d[i], cap_dh[i], exp_d[i], exp_dh[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    load_hist(1);
    clear_exp();
    model_run(4, 1'b1);
    model_run(4, 1'b1);
    run_capture(10, 20, 900);
    n_vec++;
    if (done_at.size() != 2 || done_at[0] != 257 || done_at[1] != 514) begin
      n_err++;
      $display("FAIL b2b_done: got %0d pulses at %0d,%0d, want 2 at 257,514", done_at.size(),
               (done_at.size() > 0) ? done_at[0] : -1, (done_at.size() > 1) ? done_at[1] : -1);
    end
    n_vec++;
    if (rd_after_done.size() < 1 || rd_after_done[0] !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_restart: rd_en after first done=%0d, want 1",
               (rd_after_done.size() > 0) ? int'(rd_after_done[0]) : -1);
    end
    n_vec++;
    if (cap_a.size() != exp_a.size() || cap_da.size() != exp_da.size()) begin
      n_err++;
      $display("FAIL b2b_write_count: eva=%0d decay=%0d, want %0d %0d",
               cap_a.size(), cap_da.size(), exp_a.size(), exp_da.size());
    end
    for (int i = 0; i < exp_a.size() && i < cap_a.size() && i < cap_da.size(); i++) begin
      n_vec++;
      if (cap_a[i] != exp_a[i] || cap_d[i] != exp_d[i] ||
          cap_dh[i] != exp_dh[i] || cap_de[i] != exp_de[i]) begin
        n_err++;
        $display("FAIL b2b[%0d]: got a=%0d d=%0d h=%0d e=%0d, want a=%0d d=%0d h=%0d e=%0d",
                 i, cap_a[i], cap_d[i], cap_dh[i], cap_de[i], exp_a[i], exp_d[i], exp_dh[i], exp_de[i]);
      end
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_no_third_run: busy=%b done=%b, want 0 0", busy, done);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    load_hist(2);
    @(negedge clk);
    update_EVA = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      update_EVA = 1'b0;
      if (hist_rd_en && hist_rd_addr == 7'd60) begin
        found = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL mid_reach_age60: got no read of age 60, want one");
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || eva_wr_en !== 1'b0 || eva_valid !== 1'b0 || hist_wr_en !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL mid_abort: busy=%b ewr=%b valid=%b hwr=%b done=%b, want 0",
               busy, eva_wr_en, eva_valid, hist_wr_en, done);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || eva_wr_en !== 1'b0 || hist_rd_en !== 1'b0) begin
        n_err++;
        $display("FAIL mid_quiet cyc%0d: busy=%b ewr=%b rd=%b, want 0", c, busy, eva_wr_en, hist_rd_en);
      end
    end
    load_hist(3);
    clear_exp();
    model_run(4, 1'b1);
    run_capture(-10, -10, 400);
    n_vec++;
    if (done_at.size() != 1 || done_at[0] != 257 || eva_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mid_clean_run: pulses=%0d valid=%b, want 1 at 257 valid=1", done_at.size(), eva_valid);
    end
    for (int i = 0; i < exp_a.size(); i++) begin
      n_vec++;
      if (i >= cap_a.size() || cap_a[i] != exp_a[i] || cap_d[i] != exp_d[i]) begin
        n_err++;
        $display("FAIL mid_clean[%0d]: got %0d, want addr=%0d data=%0d",
                 i, (i < cap_d.size()) ? cap_d[i] : -99999, exp_a[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 2; r++) begin
      load_hist((r == 0) ? 2 : 1);
      clear_exp();
      model_run(4, 1'b1);
      run_capture(-10, -10, 400);
      n_vec++;
      if (cap_a.size() != NA || cap_da.size() != NA) begin
        n_err++;
        $display("FAIL rand%0d_counts: eva=%0d decay=%0d, want %0d", r, cap_a.size(), cap_da.size(), NA);
      end
      for (int i = 0; i < NA && i < cap_a.size() && i < cap_da.size(); i++) begin
        n_vec++;
        if (cap_a[i] != exp_a[i] || cap_d[i] != exp_d[i] || cap_da[i] != exp_da[i] ||
            cap_dh[i] != exp_dh[i] || cap_de[i] != exp_de[i]) begin
          n_err++;
          $display("FAIL rand%0d[%0d]: got a=%0d d=%0d h=%0d e=%0d, want a=%0d d=%0d h=%0d e=%0d",
                   r, i, cap_a[i], cap_d[i], cap_dh[i], cap_de[i], exp_a[i], exp_d[i], exp_dh[i], exp_de[i]);
        end
      end
    end
  endtask

  task automatic test_gain0_clamp();
    int ga[$], gd[$];
    int gdone;
    gdone = -1;
    for (int a = 0; a < NA; a++) begin
      ref_hit[a] = 65535; ref_ev[a] = 0;
    end
    clear_exp();
    model_run(0, 1'b0);
    @(negedge clk);
    g0_update = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      g0_update = 1'b0;
      if (g0_eva_en) begin
        ga.push_back(int'(g0_eva_addr));
        gd.push_back(int'($signed(g0_eva_data)));
      end
      if (g0_done) begin
        gdone = n;
        break;
      end
    end
    n_vec++;
    if (gdone != 257 || ga.size() != NA) begin
      n_err++;
      $display("FAIL g0_run: done at %0d writes=%0d, want 257 %0d", gdone, ga.size(), NA);
    end
    n_vec++;
    if (gd.size() < 2 || gd[0] != 0 || gd[1] != -32768) begin
      n_err++;
      $display("FAIL g0_edges: age127=%0d age126=%0d, want 0 -32768",
               (gd.size() > 0) ? gd[0] : 99999, (gd.size() > 1) ? gd[1] : 99999);
    end
    for (int i = 0; i < exp_a.size() && i < ga.size(); i++) begin
      n_vec++;
      if (ga[i] != exp_a[i] || gd[i] != exp_d[i]) begin
        n_err++;
        $display("FAIL g0[%0d]: got addr=%0d data=%0d, want addr=%0d data=%0d",
                 i, ga[i], gd[i], exp_a[i], exp_d[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    update_EVA = 1'b0;
    g0_update = 1'b0;
    test_reset();
    test_zero_hist();
    test_single_hit();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_gain0_clamp();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
